// File: rtl/aes_key_ctrl.sv
// rtl/aes_key_ctrl.sv - AES-128 key-expansion sequencer for aes_key_gen
// Optional round-key backpressure: define AES_KEY_STALL_EN.
module aes_key_ctrl #(
    parameter int         NUM_ROUNDS = 10,
    parameter logic [7:0] RCON_INIT  = 8'h01
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] key_in,
    output logic [127:0] kg_key,
    output logic         kg_en,
    output logic         kg_next_rnd,
    output logic [7:0]   kg_r_con,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

    localparam logic [3:0] LAST_STEP = 4'(NUM_ROUNDS);

    state_t     state;
    logic       adv_q;
    logic       adv;
    logic       ready_ok;
    logic       handoff;
    logic [3:0] step;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef AES_KEY_STALL_EN
    // key_gen only advances once the key it currently holds has been taken
    assign ready_ok = rk_ready;
    assign adv      = adv_q & (~rk_valid | rk_ready);
`else
    logic unused_rk_ready;
    assign unused_rk_ready = rk_ready;
    assign ready_ok        = 1'b1;
    assign adv             = adv_q;
`endif

    assign kg_en   = adv;
    assign handoff = (state == DONE) & rk_valid & (rk_round == LAST_STEP) & ready_ok;
    assign done    = handoff & ~abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            kg_key      <= '0;
            adv_q       <= 1'b0;
            kg_next_rnd <= 1'b0;
            kg_r_con    <= RCON_INIT;
            rk_valid    <= 1'b0;
            rk_round    <= 4'd0;
            busy        <= 1'b0;
            step        <= 4'd0;
        end else begin
`ifdef AES_KEY_STALL_EN
            rk_valid <= adv | (rk_valid & ~rk_ready);
`else
            rk_valid <= adv;
`endif
            if (adv)
                rk_round <= rk_round + 4'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        kg_key      <= key_in;
                        adv_q       <= 1'b1;
                        kg_next_rnd <= 1'b0;
                        kg_r_con    <= RCON_INIT;
                        step        <= 4'd1;
                        rk_round    <= 4'd0;
                        rk_valid    <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                LOAD, EXPAND: begin
                    // step counts kg_en pulses including the one in flight
                    if (adv) begin
                        if (step == LAST_STEP) begin
                            state <= DONE;
                            adv_q <= 1'b0;
                        end else begin
                            state       <= EXPAND;
                            kg_next_rnd <= 1'b1;
                            kg_r_con    <= xtime(kg_r_con);
                            step        <= step + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (handoff) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (abort && state != IDLE) begin
                state    <= IDLE;
                adv_q    <= 1'b0;
                rk_valid <= 1'b0;
                busy     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_ctrl.sv
// tb/tb_aes_key_ctrl.sv - scoreboard bench for aes_key_ctrl
// Expected kg_en/round-key/done events are queued with their cycle numbers.
module tb_aes_key_ctrl;

`ifdef AES_KEY_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [127:0] key_in;
    logic [127:0] kg_key;
    logic         kg_en;
    logic         kg_next_rnd;
    logic [7:0]   kg_r_con;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic         rk_ready;
    logic         busy;
    logic         done;

    aes_key_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .key_in(key_in),
        .kg_key(kg_key), .kg_en(kg_en), .kg_next_rnd(kg_next_rnd), .kg_r_con(kg_r_con),
        .rk_valid(rk_valid), .rk_round(rk_round), .rk_ready(rk_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic         nrnd;
        logic [7:0]   rcon;
        logic [127:0] key;
    } en_t;

    en_t  eq[$];
    int   rq_cyc[$];
    int   rq_rnd[$];
    int   dq[$];
    bit   busy_map[int];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [7:0] rcon_tbl [10];
    en_t  e_cur;
    int   i_cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: 10 kg_en pulses at t0+p, round r shown at t0+1+r, done at t0+11;
    // a d-cycle stall on round sr delays every later event by d; abort at t0+ab truncates.
    task automatic push_exp(input int t0, input logic [127:0] k, input int sr, input int d, input int ab);
        int last;
        for (int p = 1; p <= 10; p++) begin
            en_t e;
            if (ab != 0 && p > ab) break;
            e.cyc  = t0 + p + ((p > sr) ? d : 0);
            e.nrnd = (p > 1);
            e.rcon = rcon_tbl[p - 1];
            e.key  = k;
            eq.push_back(e);
        end
        for (int r = 1; r <= 10; r++) begin
            if (ab != 0 && r > ab - 1) break;
            rq_cyc.push_back(t0 + 1 + r + ((r >= sr) ? d : 0));
            rq_rnd.push_back(r);
        end
        last = (ab != 0) ? t0 + ab : t0 + 11 + d;
        if (ab == 0) dq.push_back(t0 + 11 + d);
        for (int c = t0 + 1; c <= last; c++) busy_map[c] = 1'b1;
    endtask

    task automatic run(input logic [127:0] k, input int sr, input int sd, input int ab);
        int t0;
        t0 = cyc;
        start  = 1'b1;
        key_in = k;
        push_exp(t0, k, sr, STALL ? sd : 0, ab);
        for (int i = 1; i <= 14 + sd; i++) begin
            tick();
            start    = 1'b0;
            key_in   = rnd128();
            abort    = (ab != 0 && i == ab);
            rk_ready = (i >= sr + 1 && i <= sr + sd) ? 1'b0 : (STALL ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        abort = 1'b0;
    endtask

    task automatic run_b2b(input logic [127:0] k1, input logic [127:0] k2);
        int t0;
        t0 = cyc;
        start  = 1'b1;
        key_in = k1;
        push_exp(t0, k1, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            rk_ready = STALL ? 1'b1 : 1'($urandom_range(0, 1));
            key_in   = (i == 12) ? k2 : rnd128();
        end
        push_exp(t0 + 12, k2, 0, 0, 0);
        tick();
        start = 1'b0;
        repeat (13) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_kg_key"}, kg_key, '0);
        chk({tag, "_kg_en"}, kg_en, 1'b0);
        chk({tag, "_kg_next_rnd"}, kg_next_rnd, 1'b0);
        chk({tag, "_kg_r_con"}, kg_r_con, 8'h01);
        chk({tag, "_rk_valid"}, rk_valid, 1'b0);
        chk({tag, "_rk_round"}, rk_round, 4'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (kg_en || (eq.size() > 0 && eq[0].cyc == cyc)) begin
                if (eq.size() == 0) chk("kg_en_unexpected", kg_en, 1'b0);
                else begin
                    e_cur = eq.pop_front();
                    chk("kg_en_cycle", cyc, e_cur.cyc);
                    chk("kg_en", kg_en, 1'b1);
                    chk("kg_r_con", kg_r_con, e_cur.rcon);
                    chk("kg_next_rnd", kg_next_rnd, e_cur.nrnd);
                    chk("kg_key", kg_key, e_cur.key);
                end
            end
            if ((rk_valid && (rk_ready || !STALL)) || (rq_cyc.size() > 0 && rq_cyc[0] == cyc)) begin
                if (rq_cyc.size() == 0) chk("rk_valid_unexpected", rk_valid, 1'b0);
                else begin
                    i_cur = rq_cyc.pop_front();
                    chk("rk_cycle", cyc, i_cur);
                    chk("rk_valid", rk_valid, 1'b1);
                    i_cur = rq_rnd.pop_front();
                    chk("rk_round", rk_round, i_cur);
                end
            end
            if (done || (dq.size() > 0 && dq[0] == cyc)) begin
                if (dq.size() == 0) chk("done_unexpected", done, 1'b0);
                else begin
                    i_cur = dq.pop_front();
                    chk("done_cycle", cyc, i_cur);
                    chk("done", done, 1'b1);
                end
            end
            chk("busy", busy, busy_map.exists(cyc));
        end
    end

    initial begin
        rcon_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        rst = 1'b1; start = 1'b0; abort = 1'b0; rk_ready = 1'b0; key_in = '0;
        repeat (3) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (2) tick();

        run(128'h328c4fe405b593bc2010628c937b61e3, 0, 0, 0);
        for (int n = 0; n < 3; n++) run(rnd128(), 0, 0, 0);
        run_b2b(rnd128(), rnd128());
        run(rnd128(), 0, 0, 5);
        for (int n = 0; n < 3; n++) run(rnd128(), 0, 0, $urandom_range(1, 11));
        run(rnd128(), 0, 0, 0);
        run(rnd128(), 3, 4, 0);
        for (int n = 0; n < 2; n++) run(rnd128(), $urandom_range(1, 10), $urandom_range(1, 5), 0);

        // asynchronous reset in the middle of EXPAND
        start = 1'b1; key_in = rnd128();
        push_exp(cyc, key_in, 0, 0, 0);
        tick();
        start = 1'b0;
        repeat (4) tick();
        #1 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        eq.delete(); rq_cyc.delete(); rq_rnd.delete(); dq.delete(); busy_map.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_r_con", kg_r_con, 8'h01);
        repeat (2) tick();
        run(rnd128(), 0, 0, 0);

        chk("en_queue_drained", eq.size(), 0);
        chk("rk_queue_drained", rq_cyc.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
